// File: rtl/approx_mult_pkg.sv
// Shared types for the pipelined approximate multiplier.
// Accuracy modes and the helper that decides which modes are counted.
package approx_mult_pkg;

  typedef enum logic [1:0] {
    MODE_PRECISE = 2'b00,
    MODE_APPROX  = 2'b01,
    MODE_DROPLL  = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  function automatic logic is_approx(mode_t m);
    return (m == MODE_APPROX) || (m == MODE_DROPLL);
  endfunction

endpackage

// File: rtl/approx_half_mult.sv
// Combinational HxH sub-multiplier.
// When approx_en is set, partial-product columns below TRUNC_COLS are dropped.
module approx_half_mult
  import approx_mult_pkg::*;
#(
  parameter int H          = 16,
  parameter int TRUNC_COLS = 4
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  input  logic           approx_en,
  output logic [2*H-1:0] p
);

  logic [H-1:0] row;

  always_comb begin
    p   = '0;
    row = '0;
    for (int j = 0; j < H; j++) begin
      row = '0;
      for (int i = 0; i < H; i++) begin
        if (!approx_en || (i + j) >= TRUNC_COLS)
          row[i] = x[i];
      end
      if (y[j])
        p = p + ({{H{1'b0}}, row} << j);
    end
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage approximate multiplier: operands, partial products, combine.
// One global stall freezes every stage; bubbles travel as invalid stages.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W          = 32,
  parameter int TRUNC_COLS = 4,
  parameter int TAG_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   product,
  output logic [TAG_W-1:0] out_tag,
  output logic             mode_err,
  output logic [CNT_W-1:0] approx_count,
  input  logic             cnt_clr,
  output logic             busy
);

  localparam int H = W / 2;

  logic stall;
  logic adv;

  assign stall    = (out_valid && !out_ready) || !clk_en;
  assign adv      = !stall;
  assign in_ready = !stall;

  // S1
  logic             v1;
  logic [W-1:0]     a1;
  logic [W-1:0]     b1;
  mode_t            m1;
  logic [TAG_W-1:0] t1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      m1 <= MODE_PRECISE;
      t1 <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1 <= a;
        b1 <= b;
        m1 <= mode_t'(mode);
        t1 <= in_tag;
      end
    end
  end

  logic         apx1;
  logic [W-1:0] ll_c;
  logic [W-1:0] lh_c;
  logic [W-1:0] hl_c;
  logic [W-1:0] hh_c;

  assign apx1 = (m1 == MODE_APPROX);

  approx_half_mult #(.H(H), .TRUNC_COLS(TRUNC_COLS)) u_ll (
    .x(a1[H-1:0]), .y(b1[H-1:0]), .approx_en(apx1), .p(ll_c)
  );
  approx_half_mult #(.H(H), .TRUNC_COLS(TRUNC_COLS)) u_lh (
    .x(a1[H-1:0]), .y(b1[W-1:H]), .approx_en(apx1), .p(lh_c)
  );
  approx_half_mult #(.H(H), .TRUNC_COLS(TRUNC_COLS)) u_hl (
    .x(a1[W-1:H]), .y(b1[H-1:0]), .approx_en(apx1), .p(hl_c)
  );
  approx_half_mult #(.H(H), .TRUNC_COLS(TRUNC_COLS)) u_hh (
    .x(a1[W-1:H]), .y(b1[W-1:H]), .approx_en(1'b0), .p(hh_c)
  );

  // S2
  logic             v2;
  logic [W-1:0]     ll2;
  logic [W-1:0]     lh2;
  logic [W-1:0]     hl2;
  logic [W-1:0]     hh2;
  mode_t            m2;
  logic [TAG_W-1:0] t2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2  <= 1'b0;
      ll2 <= '0;
      lh2 <= '0;
      hl2 <= '0;
      hh2 <= '0;
      m2  <= MODE_PRECISE;
      t2  <= '0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        ll2 <= ll_c;
        lh2 <= lh_c;
        hl2 <= hl_c;
        hh2 <= hh_c;
        m2  <= m1;
        t2  <= t1;
      end
    end
  end

  logic [W-1:0]   ll_used;
  logic [W-1:0]   band;
  logic [2*W-1:0] exact_p;
  logic [2*W-1:0] apx_p;
  logic [2*W-1:0] comb_p;

  // Approx band ORs overlapping bits instead of rippling carries
  always_comb begin
    ll_used = (m2 == MODE_DROPLL) ? '0 : ll2;
    exact_p = {hh2, {W{1'b0}}}
            + {{H{1'b0}}, lh2, {H{1'b0}}}
            + {{H{1'b0}}, hl2, {H{1'b0}}}
            + {{W{1'b0}}, ll_used};
    band    = {{H{1'b0}}, ll2[W-1:H]}
            | lh2
            | hl2
            | {hh2[H-1:0], {H{1'b0}}};
    apx_p   = {hh2[W-1:H], band, ll2[H-1:0]};
    comb_p  = (m2 == MODE_APPROX) ? apx_p : exact_p;
  end

  // S3
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      product   <= '0;
      out_tag   <= '0;
      mode_err  <= 1'b0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        product  <= comb_p;
        out_tag  <= t2;
        mode_err <= (m2 == MODE_RSVD);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      approx_count <= '0;
    end else if (clk_en) begin
      if (cnt_clr)
        approx_count <= '0;
      else if (adv && in_valid && is_approx(mode_t'(mode))
               && approx_count != {CNT_W{1'b1}})
        approx_count <= approx_count + 1'b1;
    end
  end

  assign busy = v1 | v2 | out_valid;

endmodule

// File: doc/approx_mult_pipe.md
# approx_mult_pipe

Parametrised, pipelined approximate multiplier for the mpeg2 datapath (IDCT/motion-compensation arithmetic). It is the next generation of the fixed 32x32 approximate multiplier. It adds generic operand width, per-transaction accuracy mode, valid/ready flow control with a transaction tag, and a saturating approximate-operation counter. It sits between the operand-issuing datapath stage and its accumulator.

## Interface
- `W`, default 32: operand width. Even, 8..64. `H = W/2`.
- `TRUNC_COLS`, default 4: in approximate mode, partial-product columns below this index are dropped inside each sub-multiplier. Range 0..H-1.
- `TAG_W`, default 4: width of the sideband tag.
- `CNT_W`, default 16: width of the approximate-operation counter.
- `clk` input 1: the single clock.
- `rst` input 1: reset. Synchronous, active-high.
- `clk_en` input 1: pipeline advance enable. When 0, all state is frozen.
- `in_valid` input 1: operand offer.
- `in_ready` output 1: operand accept.
- `a` input W: multiplicand, unsigned.
- `b` input W: multiplier, unsigned.
- `mode` input 2: accuracy mode, values from `approx_mult_pkg::mode_t`.
- `in_tag` input TAG_W: sideband, returned with the result.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accept.
- `product` output 2W: result.
- `out_tag` output TAG_W: tag returned with the result.
- `mode_err` output 1: set in the same beat as a result whose mode was reserved.
- `approx_count` output CNT_W: number of accepted non-precise transactions. Saturates.
- `cnt_clr` input 1: synchronous clear of `approx_count`.
- `busy` output 1: any pipeline stage holds a valid transaction.

## Operation
- Operands are split into halves: `aL/aH`, `bL/bH`. Four partial products are formed: `LL = aL*bL`, `LH = aL*bH`, `HL = aH*bL`, `HH = aH*bH`. Each is 2H bits wide.
- `HH` is always exact.
- **MODE_PRECISE (00):** `product = HH<<W + (LH+HL)<<H + LL`. Bit-exact with `a*b`. All sub-multipliers run in exact mode.
- **MODE_APPROX (01):**
  - `LL`, `LH` and `HL` are truncated. Each is the sum of the bits `x[i]&y[j]` for `i+j >= TRUNC_COLS` only.
  - `product[H-1:0] = LL[H-1:0]`.
  - Bits H..W+H-1 are the bitwise OR of all overlapping partial-product bits (`LL` upper half, `LH`, `HL`, `HH` lower half). No carries are propagated in this band.
  - Bits W+H..2W-1 = `HH[2H-1:H]`.
- **MODE_DROPLL (10):** exact carry combination with `LL` forced to 0: `product = HH<<W + (LH+HL)<<H`.
- **Reserved (11):** computed as MODE_PRECISE. `mode_err` = 1 in the output beat.
- `approx_count` increments by 1 at stage-1 acceptance when the mode is 01 or 10. It holds at all-ones.
- `cnt_clr` has priority over the increment. After a clear, the count reads 0 and the coincident accept is not counted.

## Timing
- Three register stages:
  - S1: registered operands, mode and tag.
  - S2: four registered partial products.
  - S3: registered combine, which drives the outputs.
- Latency is 3 accepted cycles from an `in_valid && in_ready` edge to `out_valid`. Throughput is one per cycle.
- `stall = out_valid && !out_ready || !clk_en`.
- `in_ready = !stall`. This is combinational and the same stall applies to the whole pipeline: no stage advances while stall is asserted.
- While stalled, `product`, `out_tag` and `mode_err` are held stable. `out_valid` stays 1 until the handshake completes.
- A bubble (`in_valid=0` on an accept cycle) propagates as an invalid stage. Bubbles are not collapsed.
- `busy = v1|v2|v3`.
- **Reset** (any cycle, including mid-stream, and regardless of `clk_en`):
  - Cleared to 0: all stage valids, `out_valid`, `product`, `out_tag`, `mode_err`, `approx_count`.
  - `in_ready` = 1 in the first cycle after reset, provided `clk_en=1`.
  - In-flight transactions are discarded.
- Simultaneous `rst` and `cnt_clr`: reset wins. The result is the same value, 0.

## Structure
- Package `approx_mult_pkg`:
  - `mode_t` enum: `MODE_PRECISE`, `MODE_APPROX`, `MODE_DROPLL`, `MODE_RSVD`.
  - `is_approx(mode_t)` function.
- Sub-module `approx_half_mult #(H, TRUNC_COLS)` has ports `x`, `y`, `approx_en` and `p[2H-1:0]`. It is purely combinational. Four instances feed the S2 registers; the `HH` instance is tied to `approx_en=0`.
- The combine and the valid/stall logic are in the top level.

## Test plan
- **Precise, single beat.** `W=32`, `a=32'hFFFF_FFFF`, `b=32'hFFFF_FFFF`, mode 00. Expect `product=64'hFFFF_FFFE_0000_0001` 3 cycles after accept, `mode_err=0`, `approx_count` unchanged.
- **Approx vs reference model.** `W=16`, `TRUNC_COLS=0`, `a=16'h00FF`, `b=16'h00FF`, mode 01. Expect `product=32'h0000_FE01`, because `LL` alone is nonzero. Then run 10k random operands against a bit-level model of the OR combine: exact match required.
- **DROPLL and reserved mode.** `a=32'h0001_0003`, `b=32'h0001_0005`, mode 10. Expect `64'h0000_0001_0008_0000`. Same operands with mode 11: expect `64'h0000_0001_0008_000F` and `mode_err=1`.
- **Back-pressure.** Stream 8 tagged ops (tags 0..7) and hold `out_ready=0` for 5 cycles mid-stream. Expect no loss or duplication, in-order tags, `product` stable during the stall, and `in_ready=0` throughout the stall.
- **Counter saturation and clear.** `CNT_W=3`. Send 9 approx ops: `approx_count` holds at 7. Assert `cnt_clr` together with an approx accept: the next value is 0.
- **Reset mid-operation.** Assert `rst` for 1 cycle with 3 ops in flight. Next cycle: `out_valid=0`, `busy=0`, `approx_count=0`. No stale result ever appears.
